// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and default geometry for the data cache controller.
//   dcache_state_e : controller FSM states
//   DC_ADDR_W      : default byte address width
//   DC_DATA_W      : default data width (one byte per line)
//   DC_INDEX_W     : default index width (2^DC_INDEX_W lines)
//   DC_TAG_W       : derived tag width
package dcache_pkg;

  localparam int DC_ADDR_W  = 8;
  localparam int DC_DATA_W  = 8;
  localparam int DC_INDEX_W = 3;
  localparam int DC_TAG_W   = DC_ADDR_W - DC_INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    AL_REQ,
    AL_WAIT
  } dcache_state_e;

endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: read/write/busy byte bus used on both sides of the cache.
//   read, write : request strobes (initiator -> responder)
//   addr, wdata : request address and store data (initiator -> responder)
//   rdata       : load data (responder -> initiator)
//   busy        : stall / busy-wait (responder -> initiator)
// Modports: master = initiator side, slave = responder side.
interface dcache_ctrl_if
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (output read, write, addr, wdata, input rdata, busy);
  modport slave  (input read, write, addr, wdata, output rdata, busy);

endinterface

// File: rtl/dcache_line_array.sv
// dcache_line_array: storage for the direct-mapped cache lines.
//   CLK, RESET          : clock, synchronous active-high reset (clears valid/dirty)
//   idx                 : line index for both the read and the write port
//   rd_valid/dirty/tag/data : asynchronous read of line idx
//   data_we, data_in    : write line data
//   tag_we, tag_in      : write tag and mark the line valid
//   dirty_we, dirty_in  : write the dirty bit
module dcache_line_array #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INDEX_W-1:0] idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               data_we,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               dirty_we,
  input  logic               dirty_in
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (tag_we)   valid_d[idx] = 1'b1;
    if (dirty_we) dirty_d[idx] = dirty_in;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (data_we) data_mem[idx] <= data_in;
      if (tag_we)  tag_mem[idx]  <= tag_in;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate byte cache controller.
//   CLK, RESET : clock, synchronous active-high reset
//   cpu (slave)  : CPU requests; cpu.busy stalls the CPU on a miss
//   mem (master) : data memory read/write/busy-wait bus
//   hit_count, miss_count : saturating statistics (only with DCACHE_STATS_EN)
// Optional feature macro: DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = DC_ADDR_W,
  parameter int DATA_W  = DC_DATA_W,
  parameter int INDEX_W = DC_INDEX_W
) (
  input  logic          CLK,
  input  logic          RESET,
  dcache_ctrl_if.slave  cpu,
  dcache_ctrl_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [7:0]    hit_count,
  output logic [7:0]    miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  dcache_state_e state_q, state_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               valid_req;
  logic               hit;

  logic               line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;

  logic               data_we, tag_we, dirty_we, dirty_in;
  logic [DATA_W-1:0]  data_in;

  assign idx       = cpu.addr[INDEX_W-1:0];
  assign req_tag   = cpu.addr[ADDR_W-1:INDEX_W];
  // Both strobes high is treated as no request at all.
  assign valid_req = cpu.read ^ cpu.write;
  assign hit       = line_valid && (line_tag == req_tag);

  dcache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .CLK      (CLK),
    .RESET    (RESET),
    .idx      (idx),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .data_we  (data_we),
    .data_in  (data_in),
    .tag_we   (tag_we),
    .tag_in   (req_tag),
    .dirty_we (dirty_we),
    .dirty_in (dirty_in)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The CPU holds its address during a miss, so idx still selects the victim
  // line while writing back and the new line while allocating.
  always_comb begin
    state_d   = state_q;
    cpu.busy  = 1'b0;
    cpu.rdata = '0;
    mem.read  = 1'b0;
    mem.write = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    data_we   = 1'b0;
    data_in   = cpu.wdata;
    tag_we    = 1'b0;
    dirty_we  = 1'b0;
    dirty_in  = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_req) begin
          if (hit) begin
            if (cpu.read) begin
              cpu.rdata = line_data;
            end else begin
              data_we  = 1'b1;
              dirty_we = 1'b1;
              dirty_in = 1'b1;
            end
          end else begin
            cpu.busy = 1'b1;
            state_d  = (line_valid && line_dirty) ? WB_REQ : AL_REQ;
          end
        end
      end
      WB_REQ, WB_WAIT: begin
        cpu.busy  = 1'b1;
        mem.write = 1'b1;
        mem.addr  = {line_tag, idx};
        mem.wdata = line_data;
        if (state_q == WB_REQ) begin
          if (mem.busy) state_d = WB_WAIT;
        end else if (!mem.busy) begin
          dirty_we = 1'b1;
          state_d  = AL_REQ;
        end
      end
      AL_REQ, AL_WAIT: begin
        cpu.busy = 1'b1;
        mem.read = 1'b1;
        mem.addr = cpu.addr;
        if (state_q == AL_REQ) begin
          if (mem.busy) state_d = AL_WAIT;
        end else if (!mem.busy) begin
          data_we  = 1'b1;
          data_in  = mem.rdata;
          tag_we   = 1'b1;
          dirty_we = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;
  // Set on the allocate->IDLE step so the completing re-hit is not counted.
  logic       refill_q, refill_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    refill_d   = refill_q;
    if (state_q == IDLE && valid_req) begin
      if (hit) begin
        if (!refill_q && hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
        refill_d = 1'b0;
      end else if (miss_cnt_q != 8'hFF) begin
        miss_cnt_d = miss_cnt_q + 8'd1;
      end
    end
    if (state_q == AL_WAIT && !mem.busy) refill_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      refill_q   <= refill_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller placed between the CPU control path and the 8-bit data memory.
- CPU side is a responder: it receives read/write requests and stalls the CPU through cpu_busy.
- Memory side is the initiator of the data-memory read/write/busy_wait protocol. It drives mem_read, mem_write, mem_addr and mem_wdata, and obeys mem_busy.
- Line size is one byte, matching the memory's byte interface.

Parameters:
ADDR_W, 8, byte address width
DATA_W, 8, data width
INDEX_W, 3, index bits (2^INDEX_W lines); tag width = ADDR_W-INDEX_W

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
cpu_read  input  1  CPU load request; held stable while cpu_busy=1
cpu_write  input  1  CPU store request; held stable while cpu_busy=1
cpu_addr  input  ADDR_W  request address
cpu_wdata  input  DATA_W  store data
cpu_rdata  output  DATA_W  load data, valid when cpu_read=1 and cpu_busy=0
cpu_busy  output  1  stall to PC/control
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid when mem_busy falls
mem_busy  input  1  memory busy_wait

Behaviour:
- Address split: index=cpu_addr[INDEX_W-1:0], tag=cpu_addr[ADDR_W-1:INDEX_W]. Each line holds valid, dirty, tag and data.
- hit = valid[index] && tag match. Computed combinationally.
- Valid request: exactly one of cpu_read or cpu_write is high. If both are high, the request is ignored: no state change and cpu_busy=0.

States: IDLE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT.

- IDLE:
  - cpu_busy = valid request && !hit (combinational, same cycle).
  - Read hit: cpu_rdata = line data combinationally; zero stall.
  - Write hit: at posedge, data<=cpu_wdata and dirty<=1; zero stall.
  - Miss with victim valid and dirty: go to WB_REQ.
  - Any other miss: go to AL_REQ.
- WB_REQ:
  - Drive mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim data.
  - Go to WB_WAIT when mem_busy=1.
- WB_WAIT:
  - Hold mem_write and mem_addr.
  - When mem_busy=0: dirty<=0, then go to AL_REQ.
- AL_REQ:
  - Drive mem_read=1, mem_addr=cpu_addr.
  - Go to AL_WAIT when mem_busy=1.
- AL_WAIT:
  - Hold mem_read.
  - When mem_busy=0: data<=mem_rdata, tag<=tag, valid<=1, dirty<=0, then go to IDLE.
  - The request now hits in IDLE and completes there, including the store for a write miss.
- Outputs outside these states: mem_read and mem_write are 0, and mem_read and mem_write are never both 1. cpu_busy=1 in every state except IDLE.
- Miss latency: 1 cycle + memory handshake per transfer + 1 cycle for the IDLE hit.
- No timeout: the controller waits indefinitely on mem_busy.
- Reset values:
  - State IDLE; all valid and dirty bits 0.
  - mem_read, mem_write = 0; mem_addr, mem_wdata = 0; cpu_rdata = 0 when not hitting; cpu_busy = 0.
- Reset mid-transfer: the transfer is abandoned, dirty data is discarded and no writeback is issued.
- cpu_addr changing while busy is a CPU protocol violation. Behaviour in that case is undefined and the bench asserts against it.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count[7:0] and miss_count[7:0]. Both are saturating counters reset to 0.
  - hit_count increments once per valid request accepted in IDLE as a hit on first presentation. The re-hit after an allocate counts as a miss only, not a hit.
  - miss_count increments on each IDLE to WB_REQ or AL_REQ transition.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - the state enum (IDLE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT);
  - ADDR_W, DATA_W and INDEX_W defaults;
  - a derived TAG_W constant.
- Sub-module dcache_line_array holds the valid, dirty, tag and data arrays:
  - asynchronous read by index;
  - synchronous write with separate enables for data, tag/valid and dirty;
  - synchronous clear of valid and dirty on RESET.
- The FSM and the hit compare stay in dcache_ctrl.

Test Plan:
1. After RESET, read 0x12; memory model raises busy for 3 cycles and returns 0xAB. Required: mem_read with mem_addr=0x12, cpu_busy=1 until the IDLE hit, then cpu_rdata=0xAB. A second read of 0x12 gives zero stall and no mem_read.
2. Write 0x55 to 0x12 (hit). Required: no mem_write, cpu_busy stays 0. A following read of 0x12 returns 0x55.
3. Then read 0x1A (same index 2, different tag). Required: mem_write to addr 0x12 with data 0x55 completes first, then mem_read to 0x1A; cpu_rdata equals the memory value.
4. After RESET, write 0x99 to 0x07 (write miss, clean victim). Required: only mem_read 0x07 is issued, never mem_write. Afterwards the line holds 0x99 and is dirty.
5. Assert RESET during AL_WAIT. Required: next cycle state=IDLE, mem_read=0, cpu_busy=0, all lines invalid, and the next read of the same address misses.
6. With DCACHE_STATS_EN defined, run scenario 1. Required: miss_count=1, hit_count=1. After 300 hits, hit_count saturates at 255.
